seq_detector: RTL

- Parametrised serial pattern detector; next generation of the team's fixed 5-state serial Mealy FSM blocks.
- Pattern, pattern length and overlap mode are run-time configurable. Adds an input-valid qualifier, a registered one-cycle match pulse and a saturating match counter.
- Sits between a serial bit source and control logic that reacts to framing or sync sequences.

---
 rtl/seq_detector.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector
// Description : Run-time configurable serial pattern detector. Latches a
//               pattern/length/overlap configuration, shifts qualified serial
//               bits into a history register and emits a registered one-cycle
//               match pulse plus a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clr_count,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_ok
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_UNCFG = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   eff_len;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic [MAX_LEN-1:0] len_mask;
  logic               match;

  // Clamp requested length, and pre-compute the history/fill after this bit.
  always_comb begin
    eff_len    = (pat_len > MAX_LEN_C) ? MAX_LEN_C : pat_len;
    hist_shift = {hist_q[MAX_LEN-2:0], in};
    fill_inc   = (fill_q >= MAX_LEN_C) ? MAX_LEN_C : (fill_q + LEN_W'(1));
  end

  // Mask selecting the low len_q history bits that take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  // A match is judged on the history as it will be after this valid bit.
  always_comb begin
    match = (state_q == ST_RUN) && in_valid && !cfg_load &&
            (fill_inc >= len_q) &&
            (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  // Control FSM next state: only a configuration load moves between states.
  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = (eff_len != '0) ? ST_RUN : ST_UNCFG;
    end
  end

  // Datapath next state: config latch, history shift, pulse and counter.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    if (cfg_load) begin
      // A bit arriving together with cfg_load is intentionally dropped.
      pat_d  = pattern;
      len_d  = eff_len;
      ovl_d  = overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        out_d = 1'b1;
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end

    // Clear first, then count, so a clear coinciding with a match yields 1.
    cnt_d = clr_count ? '0 : cnt_q;
    if (match && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b0;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign cfg_ok      = (state_q == ST_RUN);

endmodule
`default_nettype wire
